segment_transition_ctl: RTL and testbench
=========================================

Name: segment_transition_ctl

Overview:
Parametrised segment-swap controller for the modulation and STM engines. It generalises the two-segment, fixed-width transition scheme to NUM_SEGMENT segments, configurable index and time widths, repeat counting, and an EXT auto-rotate mode. One instance sits between the controller-register decode and each sequencer (mod, stm). It decides when the read segment changes and when playback stops.

Parameters:
NUM_SEGMENT, 2, number of memory segments (>=2)
IDX_WIDTH, 15, width of sequencer index
SYS_TIME_WIDTH, 56, width of system time
REP_WIDTH, 16, width of repeat count; all-ones = infinite
NUM_GPIO, 4, number of GPIO trigger inputs

Ports:
CLK  in  1  system clock
RST_N  in  1  synchronous active-low reset
UPDATE_SETTINGS  in  1  one-cycle pulse; latches request inputs below
REQ_RD_SEGMENT  in  $clog2(NUM_SEGMENT)  requested segment
TRANSITION_MODE  in  8  0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO, 0xF0 EXT
TRANSITION_VALUE  in  64  mode argument
REP  in  REP_WIDTH  repeats of requested segment (plays REP+1 loops)
SYS_TIME  in  SYS_TIME_WIDTH  free-running system time
GPIO_IN  in  NUM_GPIO  asynchronous-to-request trigger inputs (already synchronised to CLK)
IDX_WRAP  in  1  pulse from sequencer when index wraps last->0
SEGMENT  out  $clog2(NUM_SEGMENT)  active read segment
STOP  out  1  playback finished; sequencer holds last index
SWAP  out  1  one-cycle pulse on every segment change/restart
BUSY  out  1  request pending
ERR  out  1  sticky: last request invalid

Behaviour:
- Reset (RST_N=0 at a CLK edge): SEGMENT=0, STOP=0, SWAP=0, BUSY=0, ERR=0, loop counter=0, state IDLE. Reset mid-wait discards the pending request.
- States: IDLE -> WAIT (request pending) -> RUN_FINITE / RUN_INF / RUN_EXT; any RUN state -> WAIT on new valid request.
- UPDATE_SETTINGS at cycle t: inputs latched at t. The request is valid iff mode is in {00,01,02,F0} and REQ_RD_SEGMENT<NUM_SEGMENT.
  - Valid: ERR cleared at t+1, BUSY=1 from t+1, condition evaluated from t+1.
  - Invalid: ERR=1 at t+1, request dropped, state/SEGMENT unchanged, any earlier pending request also kept.
- Swap condition (evaluated from t+1; when true at cycle c, SEGMENT, SWAP=1, BUSY=0 take effect at c+1):
  - SYNC_IDX: IDX_WRAP=1.
  - SYS_TIME: SYS_TIME >= TRANSITION_VALUE[SYS_TIME_WIDTH-1:0] (unsigned). A time already passed swaps at t+2.
  - GPIO: rising edge of GPIO_IN[TRANSITION_VALUE[7:0] mod NUM_GPIO]. The edge detector is registered: edge seen at c = input high at c, low at c-1.
  - EXT: condition as SYNC_IDX. After the swap, rotate SEGMENT=(SEGMENT+1) mod NUM_SEGMENT on every subsequent IDX_WRAP with a SWAP pulse each time. REP is ignored and STOP stays 0.
- On swap: loop counter=0, STOP=0. REP all-ones -> RUN_INF, else RUN_FINITE.
- Swap to the current segment is legal: restarts the loop count, pulses SWAP, clears STOP.
- RUN_FINITE loop counting:
  - Each IDX_WRAP increments the counter (REP_WIDTH+1 bits, no overflow possible).
  - When the increment makes counter == REP+1, STOP=1 the next cycle.
  - While STOP=1, IDX_WRAP is ignored. STOP holds until the next swap.
- The IDX_WRAP that triggers a SYNC_IDX/EXT swap is not counted for the new segment.
- New valid UPDATE while BUSY: the old pending request is discarded and replaced.
- UPDATE in the same cycle the old request's condition is true: the old swap completes, then the new request becomes pending (BUSY=1).
- In WAIT, the previous segment continues its RUN behaviour (counting/STOP) until the swap.

Test Plan:
- Reset -> all outputs 0. Hold RST_N=0 during a pending SYS_TIME request -> after release BUSY=0, SEGMENT=0, no SWAP ever.
- SYS_TIME: UPDATE seg=1, value=1000, REP=all-ones. SYS_TIME counts 990 upward -> SEGMENT=1 and single SWAP the cycle after SYS_TIME=1000. STOP stays 0 through 10 wraps.
- SYNC_IDX: seg=1, REP=2. Wraps at cycles 20,40,60,80 -> SEGMENT=1 at 21. STOP=1 the cycle after the third counted wrap (81). A further wrap leaves STOP=1.
- GPIO: value=2. Toggle GPIO_IN[1] -> no swap. Raise GPIO_IN[2] at cycle c -> SEGMENT changes at c+1, SWAP at c+1.
- EXT with NUM_SEGMENT=3, seg=0 from SEGMENT=0: wraps W1..W4 -> SEGMENT 0,1,2,0 after W1..W4, one SWAP per wrap, STOP=0.
- Invalid/overwrite:
  - mode=0x05 -> ERR=1, SEGMENT unchanged.
  - Then valid SYS_TIME far future plus second UPDATE SYNC_IDX seg=1 -> ERR=0, swap on next wrap, far-future time never swaps.

Source files
------------

// File: rtl/segment_transition_ctl.sv
// segment_transition_ctl
// Decides when a sequencer's read segment changes and when playback stops.
// A request (segment, trigger mode, trigger argument, repeat count) is latched
// on UPDATE_SETTINGS and held pending until its trigger condition fires. The
// segment that is already playing keeps its run behaviour while a request is
// pending.
module segment_transition_ctl #(
  parameter int NUM_SEGMENT    = 2,
  parameter int IDX_WIDTH      = 15,
  parameter int SYS_TIME_WIDTH = 56,
  parameter int REP_WIDTH      = 16,
  parameter int NUM_GPIO       = 4
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic                           UPDATE_SETTINGS,
  input  logic [$clog2(NUM_SEGMENT)-1:0] REQ_RD_SEGMENT,
  input  logic [7:0]                     TRANSITION_MODE,
  input  logic [63:0]                    TRANSITION_VALUE,
  input  logic [REP_WIDTH-1:0]           REP,
  input  logic [SYS_TIME_WIDTH-1:0]      SYS_TIME,
  input  logic [NUM_GPIO-1:0]            GPIO_IN,
  input  logic                           IDX_WRAP,
  output logic [$clog2(NUM_SEGMENT)-1:0] SEGMENT,
  output logic                           STOP,
  output logic                           SWAP,
  output logic                           BUSY,
  output logic                           ERR
);

  localparam int SEG_W  = $clog2(NUM_SEGMENT);
  localparam int GPIO_W = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1;

  localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME = 8'h01;
  localparam logic [7:0] MODE_GPIO     = 8'h02;
  localparam logic [7:0] MODE_EXT      = 8'hF0;

  // Run behaviour of the segment currently playing. A pending request
  // (WAIT) is tracked by busy_q on top of this, because the old segment
  // keeps counting/rotating until the swap actually happens.
  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_RUN_FINITE = 2'd1;
  localparam logic [1:0] ST_RUN_INF    = 2'd2;
  localparam logic [1:0] ST_RUN_EXT    = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [SEG_W-1:0]          seg_q, seg_d;
  logic                      stop_q, stop_d;
  logic                      swap_q, swap_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;
  logic [REP_WIDTH:0]        cnt_q, cnt_d;
  logic [REP_WIDTH-1:0]      rep_q, rep_d;
  logic [SEG_W-1:0]          req_seg_q, req_seg_d;
  logic [7:0]                req_mode_q, req_mode_d;
  logic [63:0]               req_val_q, req_val_d;
  logic [REP_WIDTH-1:0]      req_rep_q, req_rep_d;
  logic [NUM_GPIO-1:0]       gpio_prev_q, gpio_prev_d;

  logic                      mode_ok_s;
  logic                      seg_ok_s;
  logic [GPIO_W-1:0]         gpio_sel_s;
  logic                      gpio_edge_s;
  logic                      cond_s;
  logic                      swap_cond_s;
  logic [REP_WIDTH:0]        cnt_inc_s;
  logic [REP_WIDTH:0]        rep_lim_s;
  logic [SEG_W-1:0]          seg_next_s;
  logic                      idx_unused_s;

  assign idx_unused_s = ^{req_val_q[63:SYS_TIME_WIDTH], (IDX_WIDTH > 0)};

  // Request validation, trigger evaluation and loop-count helpers.
  always_comb begin
    mode_ok_s   = (TRANSITION_MODE == MODE_SYNC_IDX) || (TRANSITION_MODE == MODE_SYS_TIME) ||
                  (TRANSITION_MODE == MODE_GPIO)     || (TRANSITION_MODE == MODE_EXT);
    seg_ok_s    = ({1'b0, REQ_RD_SEGMENT} < (SEG_W+1)'(NUM_SEGMENT));
    gpio_sel_s  = GPIO_W'(req_val_q[7:0] % 8'(NUM_GPIO));
    gpio_edge_s = GPIO_IN[gpio_sel_s] & ~gpio_prev_q[gpio_sel_s];
    case (req_mode_q)
      MODE_SYNC_IDX: cond_s = IDX_WRAP;
      MODE_EXT:      cond_s = IDX_WRAP;
      MODE_SYS_TIME: cond_s = (SYS_TIME >= req_val_q[SYS_TIME_WIDTH-1:0]);
      MODE_GPIO:     cond_s = gpio_edge_s;
      default:       cond_s = 1'b0;
    endcase
    swap_cond_s = busy_q & cond_s;
    cnt_inc_s   = cnt_q + (REP_WIDTH+1)'(1);
    rep_lim_s   = {1'b0, rep_q} + (REP_WIDTH+1)'(1);
    if (seg_q == SEG_W'(NUM_SEGMENT - 1)) begin
      seg_next_s = '0;
    end else begin
      seg_next_s = seg_q + SEG_W'(1);
    end
  end

  // Next-state: swap has priority over old-segment run behaviour; a new
  // request is latched independently so it can follow a completing swap.
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    stop_d      = stop_q;
    swap_d      = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    req_seg_d   = req_seg_q;
    req_mode_d  = req_mode_q;
    req_val_d   = req_val_q;
    req_rep_d   = req_rep_q;
    gpio_prev_d = GPIO_IN;

    if (swap_cond_s) begin
      seg_d  = req_seg_q;
      swap_d = 1'b1;
      busy_d = 1'b0;
      stop_d = 1'b0;
      cnt_d  = '0;
      rep_d  = req_rep_q;
      if (req_mode_q == MODE_EXT) begin
        state_d = ST_RUN_EXT;
      end else if (&req_rep_q) begin
        state_d = ST_RUN_INF;
      end else begin
        state_d = ST_RUN_FINITE;
      end
    end else begin
      case (state_q)
        ST_RUN_FINITE: begin
          if (IDX_WRAP && !stop_q) begin
            cnt_d = cnt_inc_s;
            if (cnt_inc_s == rep_lim_s) begin
              stop_d = 1'b1;
            end else begin
              stop_d = stop_q;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_RUN_EXT: begin
          if (IDX_WRAP) begin
            seg_d  = seg_next_s;
            swap_d = 1'b1;
          end else begin
            seg_d  = seg_q;
          end
        end
        ST_RUN_INF: state_d = state_q;
        ST_IDLE:    state_d = state_q;
        default:    state_d = ST_IDLE;
      endcase
    end

    if (UPDATE_SETTINGS) begin
      if (mode_ok_s && seg_ok_s) begin
        req_seg_d  = REQ_RD_SEGMENT;
        req_mode_d = TRANSITION_MODE;
        req_val_d  = TRANSITION_VALUE;
        req_rep_d  = REP;
        busy_d     = 1'b1;
        err_d      = 1'b0;
      end else begin
        err_d      = 1'b1;
      end
    end else begin
      err_d = err_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      seg_q       <= '0;
      stop_q      <= 1'b0;
      swap_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      rep_q       <= '0;
      req_seg_q   <= '0;
      req_mode_q  <= 8'h00;
      req_val_q   <= 64'h0;
      req_rep_q   <= '0;
      gpio_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      stop_q      <= stop_d;
      swap_q      <= swap_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      req_seg_q   <= req_seg_d;
      req_mode_q  <= req_mode_d;
      req_val_q   <= req_val_d;
      req_rep_q   <= req_rep_d;
      gpio_prev_q <= gpio_prev_d;
    end
  end

  assign SEGMENT = seg_q;
  assign STOP    = stop_q;
  assign SWAP    = swap_q;
  assign BUSY    = busy_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Testbench for segment_transition_ctl: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model.
module tb_segment_transition_ctl;

  localparam int NS  = 3;
  localparam int RW  = 4;
  localparam int NG  = 4;
  localparam int STW = 56;
  localparam int REP_INF = (1 << RW) - 1;

  logic            CLK;
  logic            RST_N;
  logic            UPDATE_SETTINGS;
  logic [1:0]      REQ_RD_SEGMENT;
  logic [7:0]      TRANSITION_MODE;
  logic [63:0]     TRANSITION_VALUE;
  logic [RW-1:0]   REP;
  logic [STW-1:0]  SYS_TIME;
  logic [NG-1:0]   GPIO_IN;
  logic            IDX_WRAP;
  logic [1:0]      SEGMENT;
  logic            STOP;
  logic            SWAP;
  logic            BUSY;
  logic            ERR;

  segment_transition_ctl #(
    .NUM_SEGMENT(NS), .IDX_WIDTH(15), .SYS_TIME_WIDTH(STW), .REP_WIDTH(RW), .NUM_GPIO(NG)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .UPDATE_SETTINGS(UPDATE_SETTINGS),
    .REQ_RD_SEGMENT(REQ_RD_SEGMENT), .TRANSITION_MODE(TRANSITION_MODE),
    .TRANSITION_VALUE(TRANSITION_VALUE), .REP(REP), .SYS_TIME(SYS_TIME),
    .GPIO_IN(GPIO_IN), .IDX_WRAP(IDX_WRAP), .SEGMENT(SEGMENT), .STOP(STOP),
    .SWAP(SWAP), .BUSY(BUSY), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int n_swap = 0;

  // Behavioural reference: what is playing, how many loops it has done,
  // and the request waiting for its trigger.
  int          m_seg, m_rep, m_loops;
  bit          m_active, m_ext, m_inf;
  bit          m_stop, m_swap, m_busy, m_err;
  int          p_mode, p_seg, p_rep;
  logic [63:0] p_val;
  logic [NG-1:0] m_prev;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit fire;
    int sel;
    if (!RST_N) begin
      m_seg = 0; m_rep = 0; m_loops = 0;
      m_active = 0; m_ext = 0; m_inf = 0;
      m_stop = 0; m_swap = 0; m_busy = 0; m_err = 0;
      m_prev = '0;
      return;
    end
    sel  = int'(p_val[7:0]) % NG;
    fire = 0;
    if (m_busy) begin
      case (p_mode)
        'h00, 'hF0: fire = IDX_WRAP;
        'h01:       fire = (SYS_TIME >= p_val[STW-1:0]);
        'h02:       fire = GPIO_IN[sel] && !m_prev[sel];
        default:    fire = 0;
      endcase
    end
    m_prev = GPIO_IN;
    m_swap = 0;
    if (fire) begin
      m_seg = p_seg; m_swap = 1; m_busy = 0; m_stop = 0; m_loops = 0;
      m_active = 1; m_ext = (p_mode == 'hF0); m_inf = (p_rep == REP_INF); m_rep = p_rep;
    end else if (IDX_WRAP && m_active) begin
      if (m_ext) begin
        m_seg = (m_seg + 1) % NS;
        m_swap = 1;
      end else if (!m_inf && !m_stop) begin
        m_loops++;
        if (m_loops == m_rep + 1) m_stop = 1;
      end
    end
    if (UPDATE_SETTINGS) begin
      if ((TRANSITION_MODE == 8'h00 || TRANSITION_MODE == 8'h01 ||
           TRANSITION_MODE == 8'h02 || TRANSITION_MODE == 8'hF0) && int'(REQ_RD_SEGMENT) < NS) begin
        p_mode = int'(TRANSITION_MODE); p_seg = int'(REQ_RD_SEGMENT);
        p_val = TRANSITION_VALUE; p_rep = int'(REP);
        m_busy = 1; m_err = 0;
      end else begin
        m_err = 1;
      end
    end
  endtask

  // One clock: model follows the same edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check_val("SEGMENT", {62'h0, SEGMENT}, m_seg);
    check_val("STOP", {63'h0, STOP}, {63'h0, m_stop});
    check_val("SWAP", {63'h0, SWAP}, {63'h0, m_swap});
    check_val("BUSY", {63'h0, BUSY}, {63'h0, m_busy});
    check_val("ERR", {63'h0, ERR}, {63'h0, m_err});
    if (SWAP === 1'b1) n_swap++;
    UPDATE_SETTINGS = 1'b0;
    IDX_WRAP = 1'b0;
    SYS_TIME = SYS_TIME + 56'd1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic request(input logic [7:0] mode, input logic [1:0] seg,
                         input logic [63:0] val, input logic [RW-1:0] rep);
    TRANSITION_MODE = mode; REQ_RD_SEGMENT = seg; TRANSITION_VALUE = val; REP = rep;
    UPDATE_SETTINGS = 1'b1;
    tick();
  endtask

  // n-1 quiet cycles, then a cycle carrying an index wrap.
  task automatic wrap_after(input int n);
    ticks(n - 1);
    IDX_WRAP = 1'b1;
    tick();
  endtask

  int sw0;
  int exp_ext [4] = '{0, 1, 2, 0};

  initial begin
    RST_N = 1'b0; UPDATE_SETTINGS = 1'b0; REQ_RD_SEGMENT = 2'd0; TRANSITION_MODE = 8'h00;
    TRANSITION_VALUE = 64'h0; REP = '0; SYS_TIME = 56'd0; GPIO_IN = '0; IDX_WRAP = 1'b0;
    p_mode = 0; p_seg = 0; p_rep = 0; p_val = 64'h0;

    // Reset state
    ticks(3);
    check_val("rst_segment", {62'h0, SEGMENT}, 64'd0);
    check_val("rst_busy", {63'h0, BUSY}, 64'd0);
    check_val("rst_err", {63'h0, ERR}, 64'd0);
    RST_N = 1'b1;
    tick();

    // Reset held across a pending SYS_TIME request discards it
    request(8'h01, 2'd1, {8'h0, SYS_TIME + 56'd6}, 4'd15);
    RST_N = 1'b0;
    ticks(12);
    RST_N = 1'b1;
    sw0 = n_swap;
    ticks(20);
    check_val("rstpend_busy", {63'h0, BUSY}, 64'd0);
    check_val("rstpend_seg", {62'h0, SEGMENT}, 64'd0);
    check_val("rstpend_swaps", n_swap - sw0, 64'd0);

    // SYS_TIME trigger at 1000, infinite repeat
    SYS_TIME = 56'd990;
    sw0 = n_swap;
    request(8'h01, 2'd1, 64'd1000, 4'd15);
    ticks(20);
    check_val("systime_seg", {62'h0, SEGMENT}, 64'd1);
    check_val("systime_swaps", n_swap - sw0, 64'd1);
    for (int i = 0; i < 10; i++) wrap_after(3);
    check_val("systime_nostop", {63'h0, STOP}, 64'd0);

    // SYNC_IDX with REP=2: three counted wraps then STOP
    request(8'h00, 2'd2, 64'd0, 4'd2);
    wrap_after(19);
    check_val("sync_seg", {62'h0, SEGMENT}, 64'd2);
    wrap_after(20);
    wrap_after(20);
    check_val("sync_prestop", {63'h0, STOP}, 64'd0);
    wrap_after(20);
    check_val("sync_stop", {63'h0, STOP}, 64'd1);
    wrap_after(20);
    check_val("sync_stophold", {63'h0, STOP}, 64'd1);

    // GPIO trigger on pin 2, other pins ignored
    request(8'h02, 2'd1, 64'd2, 4'd3);
    GPIO_IN = 4'b0010; ticks(2);
    GPIO_IN = 4'b0000; ticks(2);
    check_val("gpio_wrongpin", {62'h0, SEGMENT}, 64'd2);
    GPIO_IN = 4'b0100; tick();
    check_val("gpio_seg", {62'h0, SEGMENT}, 64'd1);
    check_val("gpio_swap", {63'h0, SWAP}, 64'd1);
    GPIO_IN = 4'b0000; tick();

    // EXT auto-rotate from segment 0
    RST_N = 1'b0; tick(); RST_N = 1'b1; tick();
    request(8'hF0, 2'd0, 64'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      wrap_after(5);
      check_val("ext_seg", {62'h0, SEGMENT}, exp_ext[i]);
      check_val("ext_swap", {63'h0, SWAP}, 64'd1);
      check_val("ext_stop", {63'h0, STOP}, 64'd0);
    end

    // Invalid mode, then overwrite of a far-future request
    request(8'h05, 2'd1, 64'd0, 4'd0);
    check_val("inv_err", {63'h0, ERR}, 64'd1);
    check_val("inv_seg", {62'h0, SEGMENT}, 64'd0);
    request(8'h01, 2'd1, 64'h00FF_FFFF_FFFF_FFFF, 4'd0);
    request(8'h00, 2'd1, 64'd0, 4'd0);
    check_val("ovr_err", {63'h0, ERR}, 64'd0);
    wrap_after(4);
    check_val("ovr_seg", {62'h0, SEGMENT}, 64'd1);
    sw0 = n_swap;
    ticks(30);
    check_val("ovr_nofar", n_swap - sw0, 64'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) RST_N = 1'b0;
      else RST_N = 1'b1;
      if ($urandom_range(0, 9) == 0) IDX_WRAP = 1'b1;
      if ($urandom_range(0, 4) == 0) GPIO_IN = NG'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 5))
          0: TRANSITION_MODE = 8'h00;
          1: TRANSITION_MODE = 8'h01;
          2: TRANSITION_MODE = 8'h02;
          3: TRANSITION_MODE = 8'hF0;
          4: TRANSITION_MODE = 8'h05;
          default: TRANSITION_MODE = 8'($urandom);
        endcase
        REQ_RD_SEGMENT = 2'($urandom_range(0, 3));
        REP = RW'($urandom);
        if (TRANSITION_MODE == 8'h01)
          TRANSITION_VALUE = {8'($urandom), SYS_TIME + 56'($urandom_range(0, 40)) - 56'd5};
        else
          TRANSITION_VALUE = {32'($urandom), 32'($urandom)};
        UPDATE_SETTINGS = 1'b1;
      end
      tick();
    end
    RST_N = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
